// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared constants for the switch egress virtual-channel demultiplexer.
//   - FSM state encoding for the frame-lock state machine
//   - Width of the optional statistics counters
// No ports (package).
// -----------------------------------------------------------------------------
package switch_pkg;

   // Frame-lock FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;   // no frame locked, next beat is a first beat
   localparam logic [1:0] ST_FWD  = 2'd1;   // frame locked to a valid VC
   localparam logic [1:0] ST_DROP = 2'd2;   // frame addressed an absent VC, discard it

   // Width of every statistics counter (wraps naturally at 2^32)
   localparam int STAT_CNT_W = 32;

endpackage

// File: rtl/switch_vc_out_slot.sv
// -----------------------------------------------------------------------------
// switch_vc_out_slot
// Single-entry AXI-Stream output register for one virtual channel.
// Loads on a routed beat, clears when drained, and supports drain+load in the
// same cycle so a steady stream passes with no bubble.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   load            - accepted input beat is routed to this slot this cycle
//   in_data/keep/last/id/dest - beat contents to capture
//   m_ready         - downstream ready
//   m_valid         - slot holds a beat
//   m_data/keep/last/id/dest  - held beat contents (stable while stalled)
//   slot_free       - slot can accept a beat this cycle (empty or draining)
// -----------------------------------------------------------------------------
module switch_vc_out_slot #(
   parameter int DATA_W = 64,
   parameter int KEEP_W = 8,
   parameter int ID_W   = 8,
   parameter int DEST_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEEP_W-1:0] in_keep,
   input  logic              in_last,
   input  logic [ID_W-1:0]   in_id,
   input  logic [DEST_W-1:0] in_dest,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic [KEEP_W-1:0] m_keep,
   output logic              m_last,
   output logic [ID_W-1:0]   m_id,
   output logic [DEST_W-1:0] m_dest,
   output logic              slot_free
);

   logic              valid_reg;
   logic [DATA_W-1:0] data_reg;
   logic [KEEP_W-1:0] keep_reg;
   logic              last_reg;
   logic [ID_W-1:0]   id_reg;
   logic [DEST_W-1:0] dest_reg;

   // Free when empty, or when the held beat leaves on this edge.
   assign slot_free = ~valid_reg | m_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         keep_reg  <= '0;
         last_reg  <= 1'b0;
         id_reg    <= '0;
         dest_reg  <= '0;
      end else begin
         if (load) begin
            // load wins over drain: valid stays high with new contents
            valid_reg <= 1'b1;
            data_reg  <= in_data;
            keep_reg  <= in_keep;
            last_reg  <= in_last;
            id_reg    <= in_id;
            dest_reg  <= in_dest;
         end else if (valid_reg && m_ready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign m_valid = valid_reg;
   assign m_data  = data_reg;
   assign m_keep  = keep_reg;
   assign m_last  = last_reg;
   assign m_id    = id_reg;
   assign m_dest  = dest_reg;

endmodule

// File: rtl/switch_egress_vc_demux.sv
// -----------------------------------------------------------------------------
// switch_egress_vc_demux
// Splits one switch egress AXI-Stream into VC_COUNT per-virtual-channel
// streams. The VC is taken from tuser on the first beat of each frame and the
// whole frame follows it. Frames addressing a VC index >= VC_COUNT are
// swallowed and reported with a one-cycle status_drop pulse.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   s_axis_*                 - input stream (tuser carries the VC index)
//   m_axis_*                 - VC_COUNT output streams, packed lane k = VC k;
//                              m_axis_tuser lane k is the constant k
//   status_drop              - pulse one cycle after a dropped frame's tlast
//
// Optional build macro SWITCH_EGRESS_VC_STATS_EN adds:
//   stat_frame_count         - per-VC count of drained tlast beats (32b each)
//   stat_drop_count          - count of dropped frames (32b)
// -----------------------------------------------------------------------------
module switch_egress_vc_demux
   import switch_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH  = 64,
   parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_ID_ENABLE   = 1,
   parameter int AXIS_ID_WIDTH    = 8,
   parameter int AXIS_DEST_ENABLE = 1,
   parameter int AXIS_DEST_WIDTH  = 4,
   parameter int VC_COUNT         = 8,
   parameter int AXIS_USER_WIDTH  = $clog2(VC_COUNT)
) (
   input  logic                                  clk,
   input  logic                                  rst,

   input  logic [AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]            s_axis_tkeep,
   input  logic                                  s_axis_tvalid,
   output logic                                  s_axis_tready,
   input  logic                                  s_axis_tlast,
   input  logic [AXIS_ID_WIDTH-1:0]              s_axis_tid,
   input  logic [AXIS_DEST_WIDTH-1:0]            s_axis_tdest,
   input  logic [AXIS_USER_WIDTH-1:0]            s_axis_tuser,

   output logic [VC_COUNT*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [VC_COUNT*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
   output logic [VC_COUNT-1:0]                   m_axis_tvalid,
   input  logic [VC_COUNT-1:0]                   m_axis_tready,
   output logic [VC_COUNT-1:0]                   m_axis_tlast,
   output logic [VC_COUNT*AXIS_ID_WIDTH-1:0]     m_axis_tid,
   output logic [VC_COUNT*AXIS_DEST_WIDTH-1:0]   m_axis_tdest,
   output logic [VC_COUNT*AXIS_USER_WIDTH-1:0]   m_axis_tuser,

   output logic                                  status_drop
`ifdef SWITCH_EGRESS_VC_STATS_EN
   ,
   output logic [VC_COUNT*STAT_CNT_W-1:0]        stat_frame_count,
   output logic [STAT_CNT_W-1:0]                 stat_drop_count
`endif
);

   localparam int USER_W = AXIS_USER_WIDTH;
   // One bit wider than tuser so VC_COUNT itself is representable.
   localparam logic [USER_W:0] VC_LIMIT = (USER_W+1)'(VC_COUNT);

   logic [1:0]          state_reg, state_next;
   logic [USER_W-1:0]   vc_reg, vc_next;
   logic                status_drop_reg;

   logic                in_range;
   logic                fwd_path;
   logic                drop_path;
   logic [USER_W-1:0]   route_vc;
   logic [VC_COUNT-1:0] route_sel;
   logic [VC_COUNT-1:0] slot_free;
   logic [VC_COUNT-1:0] slot_load;
   logic                accept;

   logic [AXIS_ID_WIDTH-1:0]   id_in;
   logic [AXIS_DEST_WIDTH-1:0] dest_in;

   assign id_in   = (AXIS_ID_ENABLE != 0)   ? s_axis_tid   : '0;
   assign dest_in = (AXIS_DEST_ENABLE != 0) ? s_axis_tdest : '0;

   // ---------------------------------------------------------------------
   // Routing decision. In IDLE the current tuser picks the VC; once locked
   // the stored VC is used and tuser on later beats is ignored.
   // ---------------------------------------------------------------------
   assign in_range  = {1'b0, s_axis_tuser} < VC_LIMIT;
   assign fwd_path  = (state_reg == ST_FWD) || ((state_reg == ST_IDLE) && in_range);
   assign drop_path = (state_reg == ST_DROP) || ((state_reg == ST_IDLE) && !in_range);
   assign route_vc  = (state_reg == ST_FWD) ? vc_reg : s_axis_tuser;

   // tready never looks at tvalid, only at the routing target and its slot.
   assign s_axis_tready = drop_path | (|(route_sel & slot_free));
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign slot_load     = route_sel & {VC_COUNT{accept}};

   // ---------------------------------------------------------------------
   // Frame-lock FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      vc_next    = vc_reg;
      case (state_reg)
         ST_IDLE: begin
            // A first beat carrying tlast is a whole frame: stay in IDLE.
            if (accept && !s_axis_tlast) begin
               if (in_range) begin
                  state_next = ST_FWD;
                  vc_next    = s_axis_tuser;
               end else begin
                  state_next = ST_DROP;
               end
            end
         end
         ST_FWD, ST_DROP: begin
            if (accept && s_axis_tlast) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= ST_IDLE;
         vc_reg          <= '0;
         status_drop_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         vc_reg          <= vc_next;
         status_drop_reg <= accept & s_axis_tlast & drop_path;
      end
   end

   assign status_drop = status_drop_reg;

   // ---------------------------------------------------------------------
   // Per-VC output slots
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < VC_COUNT; gi++) begin : g_vc
         assign route_sel[gi] = fwd_path && (route_vc == USER_W'(gi));

         switch_vc_out_slot #(
            .DATA_W (AXIS_DATA_WIDTH),
            .KEEP_W (AXIS_KEEP_WIDTH),
            .ID_W   (AXIS_ID_WIDTH),
            .DEST_W (AXIS_DEST_WIDTH)
         ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (slot_load[gi]),
            .in_data   (s_axis_tdata),
            .in_keep   (s_axis_tkeep),
            .in_last   (s_axis_tlast),
            .in_id     (id_in),
            .in_dest   (dest_in),
            .m_ready   (m_axis_tready[gi]),
            .m_valid   (m_axis_tvalid[gi]),
            .m_data    (m_axis_tdata[gi*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]),
            .m_keep    (m_axis_tkeep[gi*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH]),
            .m_last    (m_axis_tlast[gi]),
            .m_id      (m_axis_tid[gi*AXIS_ID_WIDTH +: AXIS_ID_WIDTH]),
            .m_dest    (m_axis_tdest[gi*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH]),
            .slot_free (slot_free[gi])
         );

         // Each lane's tuser identifies its own VC.
         assign m_axis_tuser[gi*USER_W +: USER_W] = USER_W'(gi);

`ifdef SWITCH_EGRESS_VC_STATS_EN
         logic [STAT_CNT_W-1:0] frame_cnt_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               frame_cnt_reg <= '0;
            end else if (m_axis_tvalid[gi] && m_axis_tready[gi] && m_axis_tlast[gi]) begin
               frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
         end

         assign stat_frame_count[gi*STAT_CNT_W +: STAT_CNT_W] = frame_cnt_reg;
`endif
      end
   endgenerate

`ifdef SWITCH_EGRESS_VC_STATS_EN
   logic [STAT_CNT_W-1:0] drop_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_reg <= '0;
      end else if (accept && s_axis_tlast && drop_path) begin
         drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
   end

   assign stat_drop_count = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_switch_egress_vc_demux.sv
// -----------------------------------------------------------------------------
// tb_switch_egress_vc_demux
// Directed bench for switch_egress_vc_demux. Instance A uses the default
// 8-VC configuration; instance B uses VC_COUNT=6 so that tuser=7 addresses an
// absent VC. Expected beats are queued when the input handshake completes and
// a monitor pops/compares them as each VC lane hands a beat downstream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_switch_egress_vc_demux;

   localparam int DW  = 64;
   localparam int KW  = 8;
   localparam int IW  = 8;
   localparam int DSW = 4;
   localparam int UW  = 3;
   localparam int VC  = 8;
   localparam int VCB = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance A signals ----------------
   logic [DW-1:0]     s_tdata;
   logic [KW-1:0]     s_tkeep;
   logic              s_tvalid, s_tready, s_tlast;
   logic [IW-1:0]     s_tid;
   logic [DSW-1:0]    s_tdest;
   logic [UW-1:0]     s_tuser;
   logic [VC*DW-1:0]  m_tdata;
   logic [VC*KW-1:0]  m_tkeep;
   logic [VC-1:0]     m_tvalid, m_tready, m_tlast;
   logic [VC*IW-1:0]  m_tid;
   logic [VC*DSW-1:0] m_tdest;
   logic [VC*UW-1:0]  m_tuser;
   logic              status_drop;

   // ---------------- instance B signals ----------------
   logic [DW-1:0]      b_s_tdata;
   logic [KW-1:0]      b_s_tkeep;
   logic               b_s_tvalid, b_s_tready, b_s_tlast;
   logic [IW-1:0]      b_s_tid;
   logic [DSW-1:0]     b_s_tdest;
   logic [UW-1:0]      b_s_tuser;
   logic [VCB*DW-1:0]  b_m_tdata;
   logic [VCB*KW-1:0]  b_m_tkeep;
   logic [VCB-1:0]     b_m_tvalid, b_m_tready, b_m_tlast;
   logic [VCB*IW-1:0]  b_m_tid;
   logic [VCB*DSW-1:0] b_m_tdest;
   logic [VCB*UW-1:0]  b_m_tuser;
   logic               b_status_drop;

`ifdef SWITCH_EGRESS_VC_STATS_EN
   logic [VC*32-1:0]  a_stat_frame;
   logic [31:0]       a_stat_drop;
   logic [VCB*32-1:0] b_stat_frame;
   logic [31:0]       b_stat_drop;
`endif

   switch_egress_vc_demux #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_ID_ENABLE(1), .AXIS_ID_WIDTH(IW),
      .AXIS_DEST_ENABLE(1), .AXIS_DEST_WIDTH(DSW), .VC_COUNT(VC), .AXIS_USER_WIDTH(UW)
   ) dut_a (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
      .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
      .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
      .status_drop(status_drop)
`ifdef SWITCH_EGRESS_VC_STATS_EN
      , .stat_frame_count(a_stat_frame), .stat_drop_count(a_stat_drop)
`endif
   );

   switch_egress_vc_demux #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_ID_ENABLE(1), .AXIS_ID_WIDTH(IW),
      .AXIS_DEST_ENABLE(1), .AXIS_DEST_WIDTH(DSW), .VC_COUNT(VCB), .AXIS_USER_WIDTH(UW)
   ) dut_b (
      .clk(clk), .rst(rst),
      .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
      .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tid(b_s_tid),
      .s_axis_tdest(b_s_tdest), .s_axis_tuser(b_s_tuser),
      .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
      .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tid(b_m_tid),
      .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser),
      .status_drop(b_status_drop)
`ifdef SWITCH_EGRESS_VC_STATS_EN
      , .stat_frame_count(b_stat_frame), .stat_drop_count(b_stat_drop)
`endif
   );

   // ---------------- scoreboard ----------------
   // keep/id/dest of each beat are taken from data[7:0], [15:8], [19:16].
   typedef struct {
      int            vc;
      logic [DW-1:0] data;
      logic          last;
      time           t_acc;
      bit            chk_lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   lat_chk = 1'b0;
   bit   in_frame = 1'b0;
   int   lock_vc = 0;
   int   a_drop_pulses = 0;
   int   b_drop_pulses = 0;
   int   b_valid_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference routing: VC is fixed by the first beat of each frame.
   task automatic model_accept(input logic [DW-1:0] d, input int user, input bit last);
      int vc;
      vc = in_frame ? lock_vc : user;
      if (!in_frame && !last) begin
         in_frame = 1'b1;
         lock_vc  = user;
      end else if (last) begin
         in_frame = 1'b0;
      end
      exp_q.push_back('{vc, d, last, $time, lat_chk});
      $display("[%0t] accept vc=%0d data=%h last=%0b", $time, vc, d, last);
   endtask

   task automatic drive(input logic [DW-1:0] d, input int user, input bit last);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = d[7:0];
      s_tid    = d[15:8];
      s_tdest  = d[19:16];
      s_tuser  = UW'(user);
      s_tlast  = last;
   endtask

   // Present one beat and hold it until accepted (bounded). Returns at posedge+1.
   task automatic send(input logic [DW-1:0] d, input int user, input bit last, output int stalls);
      bit done;
      done   = 1'b0;
      stalls = 0;
      drive(d, user, last);
      while (!done) begin
         @(negedge clk);
         if (s_tready) begin
            @(posedge clk);
            model_accept(d, user, last);
            done = 1'b1;
         end else begin
            stalls++;
            @(posedge clk);
            if (stalls > 50) begin
               check("send_timeout", 64'(stalls), 64'd0);
               done = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic b_send(input logic [DW-1:0] d, input int user, input bit last);
      b_s_tvalid = 1'b1;
      b_s_tdata  = d;
      b_s_tkeep  = d[7:0];
      b_s_tid    = d[15:8];
      b_s_tdest  = d[19:16];
      b_s_tuser  = UW'(user);
      b_s_tlast  = last;
      @(negedge clk);
      check("drop_tready", 64'(b_s_tready), 64'd1);
      $display("[%0t] drop-path beat user=%0d last=%0b tready=%0b", $time, user, last, b_s_tready);
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < VC; k++) begin
            if (m_tvalid[k] && m_tready[k]) begin
               int   idx;
               exp_t e;
               idx = -1;
               foreach (exp_q[i]) if (idx < 0 && exp_q[i].vc == k) idx = i;
               if (idx < 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat vc%0d: got data %h, required no beat", k, m_tdata[k*DW +: DW]);
               end else begin
                  e = exp_q[idx];
                  exp_q.delete(idx);
                  check($sformatf("vc%0d_data", k), m_tdata[k*DW +: DW], e.data);
                  check($sformatf("vc%0d_keep", k), 64'(m_tkeep[k*KW +: KW]), 64'(e.data[7:0]));
                  check($sformatf("vc%0d_id", k), 64'(m_tid[k*IW +: IW]), 64'(e.data[15:8]));
                  check($sformatf("vc%0d_dest", k), 64'(m_tdest[k*DSW +: DSW]), 64'(e.data[19:16]));
                  check($sformatf("vc%0d_last", k), 64'(m_tlast[k]), 64'(e.last));
                  check($sformatf("vc%0d_user", k), 64'(m_tuser[k*UW +: UW]), 64'(k));
                  if (e.chk_lat) check($sformatf("vc%0d_latency_ns", k), 64'($time - e.t_acc), 64'd5);
                  $display("[%0t] out vc=%0d data=%h last=%0b", $time, k, m_tdata[k*DW +: DW], m_tlast[k]);
               end
            end
         end
         if (status_drop) a_drop_pulses++;
         if (b_status_drop) b_drop_pulses++;
         if (|b_m_tvalid) b_valid_seen++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int st;
      logic [DW-1:0] d_vc1;

      s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tid = '0; s_tdest = '0; s_tuser = '0;
      b_s_tvalid = 0; b_s_tdata = '0; b_s_tkeep = '0; b_s_tlast = 0; b_s_tid = '0; b_s_tdest = '0; b_s_tuser = '0;
      m_tready = '1;
      b_m_tready = '0;
      rst = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_status_drop", 64'(status_drop), 64'd0);
      check("rst_tdata_any", 64'(|m_tdata), 64'd0);
      check("rst_tuser_vc5", 64'(m_tuser[5*UW +: UW]), 64'd5);
      @(posedge clk);
      #1 rst = 1'b1;
      idle(2);

      // 3-beat frame on VC5, all ready
      lat_chk = 1'b1;
      send(64'hC0DE_0005_0001_3A0F, 5, 1'b0, st); check("s1_stall_b0", 64'(st), 64'd0);
      send(64'hC0DE_0005_0002_3A1F, 5, 1'b0, st); check("s1_stall_b1", 64'(st), 64'd0);
      send(64'hC0DE_0005_0003_3A2F, 5, 1'b1, st); check("s1_stall_b2", 64'(st), 64'd0);
      idle(3);

      // tuser changes mid-frame: frame stays on VC2
      send(64'hBEEF_0002_0001_4B03, 2, 1'b0, st);
      send(64'hBEEF_0002_0002_4B07, 6, 1'b0, st);
      send(64'hBEEF_0002_0003_4B0F, 0, 1'b1, st);
      idle(3);

      // Backpressure on VC1; VC3 still drains
      lat_chk = 1'b0;
      m_tready = 8'hFD;
      d_vc1 = 64'hAAAA_0001_0001_5C11;
      send(d_vc1, 1, 1'b1, st);
      send(64'hAAAA_0003_0001_5D33, 3, 1'b1, st);
      drive(64'hAAAA_0001_0002_5C21, 1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("bp_tready_low", 64'(s_tready), 64'd0);
         check("bp_vc1_valid", 64'(m_tvalid[1]), 64'd1);
         check("bp_vc1_stable", m_tdata[1*DW +: DW], d_vc1);
      end
      check("bp_vc3_drained", 64'(m_tvalid[3]), 64'd0);
      @(posedge clk);
      #1 m_tready = '1;
      send(64'hAAAA_0001_0002_5C21, 1, 1'b0, st); check("bp_release_stall", 64'(st), 64'd0);
      send(64'hAAAA_0001_0003_5C31, 1, 1'b1, st);
      idle(3);

      // Back-to-back single-beat frames VC0, VC7, VC0
      lat_chk = 1'b1;
      send(64'h1234_0000_0001_6001, 0, 1'b1, st); check("b2b_stall_0", 64'(st), 64'd0);
      send(64'h1234_0007_0001_6702, 7, 1'b1, st); check("b2b_stall_1", 64'(st), 64'd0);
      send(64'h1234_0000_0002_6003, 0, 1'b1, st); check("b2b_stall_2", 64'(st), 64'd0);
      idle(3);

      // Drop path on the 6-VC instance: tuser=7, 4 beats, downstream not ready
      b_send(64'hDDDD_0000_0000_7001, 7, 1'b0);
      b_send(64'hDDDD_0000_0000_7002, 2, 1'b0);
      b_send(64'hDDDD_0000_0000_7003, 0, 1'b0);
      b_send(64'hDDDD_0000_0000_7004, 3, 1'b1);
      b_s_tvalid = 1'b0;
      @(negedge clk);
      check("drop_pulse_now", 64'(b_status_drop), 64'd1);
      @(negedge clk);
      check("drop_pulse_over", 64'(b_status_drop), 64'd0);
`ifdef SWITCH_EGRESS_VC_STATS_EN
      check("stat_drop_count", 64'(b_stat_drop), 64'd1);
`endif
      @(posedge clk);
      #1;

      // Reset in the middle of a VC4 frame
      send(64'h4444_0004_0001_8401, 4, 1'b0, st);
      send(64'h4444_0004_0002_8402, 4, 1'b0, st);
      rst = 1'b0;
      s_tvalid = 1'b0;
      #1;
      check("midrst_tvalid", 64'(m_tvalid), 64'd0);
      check("midrst_status_drop", 64'(status_drop), 64'd0);
      exp_q.delete();
      in_frame = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      idle(1);
      send(64'h3333_0003_0001_9301, 3, 1'b0, st);
      send(64'h3333_0003_0002_9302, 5, 1'b1, st);
      idle(4);

      // End-of-run checks
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("a_drop_pulses", 64'(a_drop_pulses), 64'd0);
      check("b_drop_pulses", 64'(b_drop_pulses), 64'd1);
      check("b_valid_seen", 64'(b_valid_seen), 64'd0);
`ifdef SWITCH_EGRESS_VC_STATS_EN
      check("stat_frames_vc3", 64'(a_stat_frame[3*32 +: 32]), 64'd1);
      check("stat_frames_vc4", 64'(a_stat_frame[4*32 +: 32]), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
